// File: rtl/rtmc_pkg.sv
// rtl/rtmc_pkg.sv - shared widths, SPI bridge constants and state type
package rtmc_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    localparam int SPI_CMD_W  = 8;
    localparam int SPI_RD_BIT = 7;

    localparam logic [15:0] SPI_TIMEOUT_RDAT = 16'hDEAD;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_CMD,
        SPI_WR_SHIFT,
        SPI_WR_BUS,
        SPI_RD_BUS,
        SPI_RD_SHIFT
    } spi_state_t;

endpackage

// File: rtl/rtmc_spi_bridge_if.sv
// rtl/rtmc_spi_bridge_if.sv - register bus between the SPI bridge and rtmc_ctrl
interface rtmc_spi_bridge_if #(
    parameter int ADDR_W = rtmc_pkg::ADDR_W,
    parameter int DATA_W = rtmc_pkg::DATA_W
);
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdat;
    logic              reg_wr;
    logic              reg_rd;
    logic [DATA_W-1:0] reg_rdat;
    logic              reg_ack;

    modport master (
        output reg_addr, reg_wdat, reg_wr, reg_rd,
        input  reg_rdat, reg_ack
    );

    modport slave (
        input  reg_addr, reg_wdat, reg_wr, reg_rd,
        output reg_rdat, reg_ack
    );
endinterface

// File: rtl/rtmc_sync.sv
// rtl/rtmc_sync.sv - multi-flop synchroniser for one asynchronous input
module rtmc_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/rtmc_spi_bridge.sv
// rtl/rtmc_spi_bridge.sv - SPI mode-0 slave driving the rtmc register bus
module rtmc_spi_bridge #(
    parameter int ADDR_W      = rtmc_pkg::ADDR_W,
    parameter int DATA_W      = rtmc_pkg::DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_sck,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic                     spi_miso_oe,
    rtmc_spi_bridge_if.master        bus,
    output logic                     err
);
    import rtmc_pkg::*;

    localparam int CNT_W = 5;
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int ST_W  = $clog2(SYNC_STAGES + 2);

    logic sck_s, cs_n_s, mosi_s;
    logic sck_q, cs_n_q;
    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [ST_W-1:0] settle;
    logic armed;

    spi_state_t state, state_n;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-2:0] tx_sr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] cap_word;
    logic              wr_q, rd_q, miso_q, err_q;
    logic              bus_pend, issued;
    logic [TO_W-1:0]   to_cnt;
    logic              to_hit, bus_done;

    logic load_cmd, load_wdat, issue, fin, rd_next, shifting;

    rtmc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .d(spi_sck), .q(sck_s)
    );
    rtmc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_n_s)
    );
    rtmc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s)
    );

    // A chip select already low when reset releases must not look like a new
    // frame, so cs falls are ignored until the synchroniser has refilled.
    assign armed    = (settle == ST_W'(SYNC_STAGES + 1));
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_rise  = cs_n_s & ~cs_n_q;
    assign cs_fall  = ~cs_n_s & cs_n_q & armed;

    assign to_hit   = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
    assign bus_done = bus_pend & (bus.reg_ack | to_hit);
    assign cap_word = bus.reg_ack ? bus.reg_rdat : DATA_W'(SPI_TIMEOUT_RDAT);
    assign shifting = (state == SPI_CMD) || (state == SPI_WR_SHIFT) || (state == SPI_RD_SHIFT);

    always_comb begin
        state_n   = state;
        load_cmd  = 1'b0;
        load_wdat = 1'b0;
        issue     = 1'b0;
        fin       = 1'b0;
        rd_next   = 1'b0;
        if (cs_rise) begin
            state_n = SPI_IDLE;
        end else begin
            unique case (state)
                SPI_IDLE: begin
                    if (cs_fall) state_n = SPI_CMD;
                end
                SPI_CMD: begin
                    if (sck_rise && bit_cnt == CNT_W'(SPI_CMD_W - 1)) begin
                        load_cmd = 1'b1;
                        state_n  = rx_sr[SPI_RD_BIT-1] ? SPI_RD_BUS : SPI_WR_SHIFT;
                    end
                end
                SPI_WR_SHIFT: begin
                    if (sck_rise && bit_cnt == CNT_W'(DATA_W - 1)) begin
                        load_wdat = 1'b1;
                        state_n   = SPI_WR_BUS;
                    end
                end
                SPI_WR_BUS, SPI_RD_BUS: begin
                    // An absorbed transaction from an aborted frame may still be pending.
                    if (!issued) begin
                        issue = !bus_pend;
                    end else if (bus_done) begin
                        fin     = 1'b1;
                        state_n = (state == SPI_WR_BUS) ? SPI_WR_SHIFT : SPI_RD_SHIFT;
                    end
                end
                SPI_RD_SHIFT: begin
                    if (sck_rise && bit_cnt == CNT_W'(DATA_W - 1)) begin
                        rd_next = 1'b1;
                        state_n = SPI_RD_BUS;
                    end
                end
                default: state_n = SPI_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SPI_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            settle   <= '0;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            addr     <= '0;
            wdat     <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            miso_q   <= 1'b0;
            err_q    <= 1'b0;
            bus_pend <= 1'b0;
            issued   <= 1'b0;
            to_cnt   <= '0;
        end else begin
            sck_q  <= sck_s;
            cs_n_q <= cs_n_s;
            if (!armed) settle <= settle + 1'b1;

            if (sck_rise) rx_sr <= {rx_sr[DATA_W-3:0], mosi_s};

            if (cs_rise || cs_fall || load_cmd || load_wdat || rd_next) begin
                bit_cnt <= '0;
            end else if (sck_rise && shifting) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (load_cmd) begin
                addr <= {rx_sr[ADDR_W-2:0], mosi_s};
            end else if (rd_next || (fin && state == SPI_WR_BUS)) begin
                addr <= addr + 1'b1;
            end

            if (load_wdat) wdat <= {rx_sr, mosi_s};

            wr_q <= issue && (state == SPI_WR_BUS);
            rd_q <= issue && (state == SPI_RD_BUS);

            if (issue) begin
                issued <= 1'b1;
            end else if (fin || cs_rise) begin
                issued <= 1'b0;
            end

            if (issue) begin
                bus_pend <= 1'b1;
                to_cnt   <= '0;
            end else if (bus_pend) begin
                if (bus.reg_ack || to_hit) begin
                    bus_pend <= 1'b0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
                if (to_hit && !bus.reg_ack) err_q <= 1'b1;
            end

            // The fall that ends the command byte or a previous word finds
            // bit_cnt at zero and must not shift the freshly captured MSB away.
            if (fin && state == SPI_RD_BUS) begin
                miso_q <= cap_word[DATA_W-1];
                tx_sr  <= cap_word[DATA_W-2:0];
            end else if (state == SPI_RD_SHIFT && sck_fall && bit_cnt != '0) begin
                miso_q <= tx_sr[DATA_W-2];
                tx_sr  <= {tx_sr[DATA_W-3:0], 1'b0};
            end else if (state_n == SPI_IDLE || state_n == SPI_CMD) begin
                miso_q <= 1'b0;
            end
        end
    end

    assign bus.reg_addr = addr;
    assign bus.reg_wdat = wdat;
    assign bus.reg_wr   = wr_q;
    assign bus.reg_rd   = rd_q;
    assign spi_miso     = miso_q;
    assign spi_miso_oe  = ~cs_n_s;
    assign err          = err_q;
endmodule

// File: tb/tb_rtmc_spi_bridge.sv
// tb/tb_rtmc_spi_bridge.sv - scoreboard bench for rtmc_spi_bridge
module tb_rtmc_spi_bridge;
    import rtmc_pkg::*;

    localparam int AW   = ADDR_W;
    localparam int HALF = 10;
    localparam int TMO  = 7;

    logic clk = 1'b0;
    logic rst, sck, cs_n, mosi;
    logic miso, miso_oe, err;

    rtmc_spi_bridge_if bus_if ();

    rtmc_spi_bridge #(.SYNC_STAGES(2), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .spi_sck(sck), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(miso_oe), .bus(bus_if), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [AW-1:0] addr;
        logic [15:0] data;
    } bus_txn_t;

    int n_chk = 0;
    int n_pass = 0;
    bus_txn_t    exp_bus[$];
    logic [15:0] exp_miso[$];
    logic [15:0] rom [0:(1<<AW)-1];
    logic [15:0] fr_w [0:7];
    bit no_ack = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Bus slave model, bus scoreboard and timeout-latency watch
    int cyc = 0;
    int last_strobe = 0;
    logic ack_due = 1'b0;
    logic prev_err = 1'b0;
    logic [AW-1:0] ack_addr = '0;
    always @(negedge clk) begin : slave
        bus_txn_t t;
        cyc++;
        bus_if.reg_ack  = ack_due;
        bus_if.reg_rdat = ack_due ? rom[ack_addr] : 16'h0;
        ack_due = 1'b0;
        if (bus_if.reg_wr === 1'b1 || bus_if.reg_rd === 1'b1) begin
            last_strobe = cyc;
            if (!no_ack) begin
                ack_due  = 1'b1;
                ack_addr = bus_if.reg_addr;
            end
            if (exp_bus.size() == 0) begin
                n_chk++;
                $display("FAIL bus_unexpected: wr=%0b rd=%0b addr=0x%0h, required no strobe",
                         bus_if.reg_wr, bus_if.reg_rd, bus_if.reg_addr);
            end else begin
                t = exp_bus.pop_front();
                check("bus_wr", 32'(bus_if.reg_wr), 32'(t.is_wr));
                check("bus_rd", 32'(bus_if.reg_rd), 32'(!t.is_wr));
                check("bus_addr", 32'(bus_if.reg_addr), 32'(t.addr));
                if (t.is_wr) check("bus_wdat", 32'(bus_if.reg_wdat), 32'(t.data));
            end
        end
        if (err === 1'b1 && prev_err === 1'b0 && !rst)
            check("err_latency", 32'(cyc - last_strobe), 32'(TMO));
        prev_err = err;
    end

    // SPI monitor: master view of MISO, sampled on its own sck rising edges
    int mon_bits = 0;
    logic [7:0]  mon_cmd = '0;
    logic [7:0]  mon_cmd_miso = '0;
    logic [15:0] mon_word = '0;
    always @(posedge sck or negedge cs_n) begin
        if (!sck) begin
            mon_bits = 0;
        end else begin
            mon_bits++;
            if (mon_bits <= 8) begin
                mon_cmd      = {mon_cmd[6:0], mosi};
                mon_cmd_miso = {mon_cmd_miso[6:0], miso};
                if (mon_bits == 8) check("miso_cmd_zero", 32'(mon_cmd_miso), 32'h0);
            end else if (mon_cmd[7]) begin
                mon_word = {mon_word[14:0], miso};
                if ((mon_bits - 8) % 16 == 0) begin
                    if (exp_miso.size() == 0) begin
                        n_chk++;
                        $display("FAIL miso_unexpected: word 0x%0h, required none", mon_word);
                    end else begin
                        check("miso_word", 32'(mon_word), 32'(exp_miso.pop_front()));
                    end
                end
            end
        end
    end

    task automatic spi_bit(input logic b, input bit raise_cs);
        mosi = b;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        if (raise_cs) cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int ndata, input bit cs_with_last);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check("miso_oe", 32'(miso_oe), 32'h1);
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], 1'b0);
        for (int i = 0; i < ndata; i++)
            spi_bit(fr_w[i/16][15-(i%16)], cs_with_last && (i == ndata - 1));
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (4*HALF) @(negedge clk);
    endtask

    function automatic logic [AW-1:0] wrap(input int a);
        return AW'(a % (1 << AW));
    endfunction

    task automatic push_bus(input bit is_wr, input int a, input logic [15:0] d);
        bus_txn_t t;
        t.is_wr = is_wr;
        t.addr  = wrap(a);
        t.data  = d;
        exp_bus.push_back(t);
    endtask

    task automatic do_write(input int a7, input int nw);
        for (int i = 0; i < nw; i++) push_bus(1'b1, (a7 % (1 << AW)) + i, fr_w[i]);
        spi_frame({1'b0, 7'(a7)}, nw*16, 1'b0);
    endtask

    task automatic do_read(input int a7, input int nw);
        for (int i = 0; i < nw; i++) begin
            push_bus(1'b0, (a7 % (1 << AW)) + i, 16'h0);
            exp_miso.push_back(rom[wrap((a7 % (1 << AW)) + i)]);
        end
        spi_frame({1'b1, 7'(a7)}, nw*16, 1'b1);
    endtask

    task automatic drained(input string tag);
        check({tag, "_bus_left"}, 32'(exp_bus.size()), 32'h0);
        check({tag, "_miso_left"}, 32'(exp_miso.size()), 32'h0);
    endtask

    initial begin
        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        for (int i = 0; i < (1 << AW); i++) rom[i] = 16'($urandom);
        rom[0] = 16'h0102;
        repeat (5) @(negedge clk);
        check("rst_reg_wr", 32'(bus_if.reg_wr), 32'h0);
        check("rst_reg_rd", 32'(bus_if.reg_rd), 32'h0);
        check("rst_reg_addr", 32'(bus_if.reg_addr), 32'h0);
        check("rst_reg_wdat", 32'(bus_if.reg_wdat), 32'h0);
        check("rst_miso", 32'(miso), 32'h0);
        check("rst_miso_oe", 32'(miso_oe), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        fr_w[0] = 16'h005A;
        do_write(3, 1);
        check("t1_err", 32'(err), 32'h0);
        drained("t1");

        do_read(0, 1);
        drained("t2");

        fr_w[0] = 16'h0001; fr_w[1] = 16'h0002; fr_w[2] = 16'h0003;
        do_write(16'h0A, 3);
        drained("t3");

        do_read((1 << AW) - 1, 2);
        drained("t4");

        fr_w[0] = 16'hA5C3;
        spi_frame(8'h06, 10, 1'b0);
        fr_w[0] = 16'h1234;
        do_write(7, 1);
        drained("t5");

        fr_w[0] = 16'hBEEF;
        spi_frame(8'h09, 16, 1'b1);
        drained("cs_with_16th");

        for (int f = 0; f < 10; f++) begin
            int a7 = int'($urandom_range(0, 127));
            int nw = int'($urandom_range(1, 3));
            for (int i = 0; i < nw; i++) fr_w[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 1) do_read(a7, nw);
            else do_write(a7, nw);
        end
        check("rand_err", 32'(err), 32'h0);
        drained("rand");

        // reset in the middle of a write frame: the frame is dropped
        fr_w[0] = 16'h7E81;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 7; i >= 0; i--) spi_bit(logic'(i == 2), 1'b0);
        for (int i = 0; i < 6; i++) spi_bit(fr_w[0][15-i], 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 6; i < 16; i++) spi_bit(fr_w[0][15-i], 1'b0);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (4*HALF) @(negedge clk);
        drained("rst_mid");

        no_ack = 1'b1;
        push_bus(1'b0, 1, 16'h0);
        exp_miso.push_back(16'hDEAD);
        spi_frame(8'h81, 16, 1'b1);
        check("t6_err_set", 32'(err), 32'h1);
        drained("t6");
        no_ack = 1'b0;
        fr_w[0] = 16'h4444;
        do_write(2, 1);
        check("t6_err_sticky", 32'(err), 32'h1);
        drained("t6b");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_err_cleared", 32'(err), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
